// File: rtl/byte_pack_pkg.sv
// byte_pack_pkg: shared lane width, byte type and lane helpers for the byte packer.
package byte_pack_pkg;
   localparam int BW = 8;
   typedef logic [BW-1:0] byte_t;
   function automatic int lanes(input int w);
      return w / BW;
   endfunction
   function automatic logic [63:0] be_full(input int n);
      return (64'd1 << n) - 64'd1;
   endfunction
endpackage

// File: rtl/byte_pack_reg_v_if.sv
// byte_pack_reg_v_if: byte-in / word-out valid-ready bundle; slave is the packer, master the environment.
interface byte_pack_reg_v_if import byte_pack_pkg::*; #(
   parameter int W = 32
);
   localparam int N = lanes(W);
   byte_t        in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic [N-1:0] out_be;
   logic         out_last;
   logic         out_valid;
   logic         out_ready;
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_be, out_last, out_valid
   );
   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_be, out_last, out_valid
   );
endinterface

// File: rtl/byte_pack_acc_v.sv
// byte_pack_acc_v: lane counter, byte accumulator and byte-enable tracker for one word.
// acc_o/be_o present the word with the current byte already merged into lane cnt.
module byte_pack_acc_v import byte_pack_pkg::*; #(
   parameter int W = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wr_i,
   input  logic                  clr_i,
   input  byte_t                 byte_i,
   output logic [W-1:0]          acc_o,
   output logic [lanes(W)-1:0]   be_o,
   output logic                  cnt_max_o
);
   localparam int N = lanes(W);
   localparam int CW = $clog2(N);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [N-1:0]  be_q, be_d;
   assign cnt_max_o = (cnt_q == CW'(N - 1));
   // Lanes above cnt are always zero, so the merged word is already zero-padded.
   always_comb begin
      acc_o = acc_q;
      acc_o[int'(cnt_q) * BW +: BW] = byte_i;
      be_o = be_q | (N'(1) << cnt_q);
      acc_d = clr_i ? '0 : wr_i ? acc_o : acc_q;
      be_d = clr_i ? '0 : wr_i ? be_o : be_q;
      cnt_d = clr_i ? '0 : wr_i ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         acc_q <= '0;
         be_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         be_q <= be_d;
      end
   end
endmodule

// File: rtl/byte_pack_reg_v.sv
// byte_pack_reg_v: packs a valid/ready byte stream into W-bit words (first byte in lane 0),
// closing early on in_last with zero padding and a byte-enable mask.
module byte_pack_reg_v import byte_pack_pkg::*; #(
   parameter int W = 32
) (
   input logic              clk,
   input logic              resetn,
   byte_pack_reg_v_if.slave bus
);
   localparam int N = lanes(W);
   logic         wr, close, cnt_max;
   logic [W-1:0] acc, out_data_q, out_data_d;
   logic [N-1:0] be, out_be_q, out_be_d;
   logic         out_valid_q, out_valid_d, out_last_q, out_last_d;
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign wr = bus.in_valid && bus.in_ready;
   assign close = wr && (bus.in_last || cnt_max);
   byte_pack_acc_v #(.W(W)) u_acc (
      .clk       (clk),
      .resetn    (resetn),
      .wr_i      (wr),
      .clr_i     (close),
      .byte_i    (bus.in_data),
      .acc_o     (acc),
      .be_o      (be),
      .cnt_max_o (cnt_max)
   );
   // A closing byte may load a new word in the same cycle the old one is consumed.
   always_comb begin
      out_valid_d = close || (out_valid_q && !bus.out_ready);
      out_data_d = close ? acc : out_data_q;
      out_be_d = close ? be : out_be_q;
      out_last_d = close ? bus.in_last : out_last_q;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q <= 1'b0;
         out_data_q <= '0;
         out_be_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
         out_be_q <= out_be_d;
         out_last_q <= out_last_d;
      end
   end
   assign bus.out_valid = out_valid_q;
   assign bus.out_data = out_data_q;
   assign bus.out_be = out_be_q;
   assign bus.out_last = out_last_q;
   hold_stable: assert property (@(posedge clk) disable iff (!resetn)
      out_valid_q && !bus.out_ready |=> out_valid_q && $stable(out_data_q) && $stable(out_be_q));
endmodule

// File: tb/tb_byte_pack_reg_v.sv
// tb_byte_pack_reg_v: directed vectors on W=32 and W=64 packers plus a random-handshake scoreboard.
module tb_byte_pack_reg_v;
   import byte_pack_pkg::*;
   logic clk = 1'b0;
   logic resetn;
   int n_chk = 0;
   int n_pass = 0;
   byte_pack_reg_v_if #(.W(32)) bus32 ();
   byte_pack_reg_v_if #(.W(64)) bus64 ();
   byte_pack_reg_v #(.W(32)) dut32 (.clk(clk), .resetn(resetn), .bus(bus32));
   byte_pack_reg_v #(.W(64)) dut64 (.clk(clk), .resetn(resetn), .bus(bus64));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l);
      bus32.in_valid = v;
      bus32.in_data = d;
      bus32.in_last = l;
      @(negedge clk);
   endtask

   task automatic drive64(input logic v, input logic [7:0] d, input logic l);
      bus64.in_valid = v;
      bus64.in_data = d;
      bus64.in_last = l;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] fr_bytes [8];
      logic [63:0] sb_q [$];
      logic [63:0] obs;
      logic [31:0] macc;
      logic [3:0] mbe;
      int mcnt;
      int sent;
      int cyc;
      logic v, l;
      logic [7:0] d;
      fr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      resetn = 1'b0;
      bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_last = 1'b0; bus32.out_ready = 1'b1;
      bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_last = 1'b0; bus64.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus32.out_valid, 0);
      chk("rst_data", bus32.out_data, 0);
      chk("rst_be", bus32.out_be, 0);
      chk("rst_last", bus32.out_last, 0);
      chk("rst_ready", bus32.in_ready, 1);
      resetn = 1'b1;
      @(negedge clk);
      // full rate, two words
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, fr_bytes[i], 1'b0);
         if (i == 2) chk("fr_idle", bus32.out_valid, 0);
         if (i == 3) begin
            chk("fr_v0", bus32.out_valid, 1);
            chk("fr_d0", bus32.out_data, 64'h44332211);
            chk("fr_be0", bus32.out_be, 4'hF);
            chk("fr_l0", bus32.out_last, 0);
         end
         if (i == 4) chk("fr_gone0", bus32.out_valid, 0);
         if (i == 7) begin
            chk("fr_v1", bus32.out_valid, 1);
            chk("fr_d1", bus32.out_data, 64'h88776655);
            chk("fr_be1", bus32.out_be, 4'hF);
            chk("fr_l1", bus32.out_last, 0);
         end
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("fr_drain", bus32.out_valid, 0);
      // partial word, then single-lane word back to back
      drive(1'b1, 8'hA1, 1'b0);
      drive(1'b1, 8'hB2, 1'b1);
      chk("pt_v", bus32.out_valid, 1);
      chk("pt_d", bus32.out_data, 64'h0000B2A1);
      chk("pt_be", bus32.out_be, 4'h3);
      chk("pt_l", bus32.out_last, 1);
      drive(1'b1, 8'hC3, 1'b1);
      chk("one_v", bus32.out_valid, 1);
      chk("one_d", bus32.out_data, 64'h000000C3);
      chk("one_be", bus32.out_be, 4'h1);
      chk("one_l", bus32.out_last, 1);
      drive(1'b0, 8'h00, 1'b0);
      chk("one_drain", bus32.out_valid, 0);
      // backpressure
      bus32.out_ready = 1'b0;
      drive(1'b1, 8'hD1, 1'b0);
      drive(1'b1, 8'hD2, 1'b0);
      drive(1'b1, 8'hD3, 1'b0);
      drive(1'b1, 8'hD4, 1'b0);
      chk("bp_v", bus32.out_valid, 1);
      bus32.in_data = 8'hE1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_rdy", bus32.in_ready, 0);
         chk("bp_d", bus32.out_data, 64'hD4D3D2D1);
         @(negedge clk);
      end
      bus32.out_ready = 1'b1;
      #1;
      chk("bp_rel", bus32.in_ready, 1);
      @(negedge clk);
      chk("bp_took", bus32.out_valid, 0);
      // word pending while the next word's closing byte waits, then both move together
      drive(1'b1, 8'hE2, 1'b0);
      drive(1'b1, 8'hE3, 1'b0);
      bus32.out_ready = 1'b0;
      drive(1'b1, 8'hE4, 1'b0);
      drive(1'b1, 8'hF1, 1'b1);
      chk("sim_hold", bus32.out_data, 64'hE4E3E2E1);
      bus32.out_ready = 1'b1;
      drive(1'b1, 8'hF1, 1'b1);
      chk("sim_v", bus32.out_valid, 1);
      chk("sim_d", bus32.out_data, 64'h000000F1);
      drive(1'b0, 8'h00, 1'b0);
      chk("sim_nodup", bus32.out_valid, 0);
      // full word closed by in_last on the top lane
      drive(1'b1, 8'h91, 1'b0);
      drive(1'b1, 8'h92, 1'b0);
      drive(1'b1, 8'h93, 1'b0);
      drive(1'b1, 8'h94, 1'b1);
      chk("fl_d", bus32.out_data, 64'h94939291);
      chk("fl_be", bus32.out_be, 4'hF);
      chk("fl_l", bus32.out_last, 1);
      // async reset with a word pending
      bus32.out_ready = 1'b0;
      drive(1'b1, 8'h5A, 1'b1);
      chk("ar_pre", bus32.out_valid, 1);
      bus32.in_valid = 1'b0;
      resetn = 1'b0;
      #1;
      chk("ar_valid", bus32.out_valid, 0);
      chk("ar_data", bus32.out_data, 0);
      chk("ar_be", bus32.out_be, 0);
      chk("ar_last", bus32.out_last, 0);
      @(negedge clk);
      resetn = 1'b1;
      bus32.out_ready = 1'b1;
      @(negedge clk);
      // reset mid-word discards partial bytes
      drive(1'b1, 8'h71, 1'b0);
      drive(1'b1, 8'h72, 1'b0);
      bus32.in_valid = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      drive(1'b1, 8'h73, 1'b1);
      chk("mr_d", bus32.out_data, 64'h00000073);
      chk("mr_be", bus32.out_be, 4'h1);
      drive(1'b0, 8'h00, 1'b0);
      // W=64
      for (int i = 0; i < 8; i++) begin
         drive64(1'b1, 8'(i + 1), 1'b0);
         if (i == 6) chk("w64_idle", bus64.out_valid, 0);
      end
      chk("w64_v", bus64.out_valid, 1);
      chk("w64_d", bus64.out_data, 64'h0807060504030201);
      chk("w64_be", bus64.out_be, 8'hFF);
      chk("w64_l", bus64.out_last, 0);
      drive64(1'b0, 8'h00, 1'b0);
      // random handshake scoreboard
      macc = '0; mbe = '0; mcnt = 0; sent = 0; cyc = 0;
      while (sent < 10000 && cyc < 60000) begin
         v = ($urandom_range(3) != 0);
         d = 8'($urandom_range(255));
         l = (sent == 9999) || ($urandom_range(5) == 0);
         bus32.in_valid = v; bus32.in_data = d; bus32.in_last = l;
         bus32.out_ready = ($urandom_range(3) != 0);
         #1;
         if (bus32.out_valid && bus32.out_ready) begin
            chk("sb_have", sb_q.size() != 0, 1);
            obs = {27'b0, bus32.out_data, bus32.out_be, bus32.out_last};
            if (sb_q.size() != 0) chk("sb_word", obs, sb_q.pop_front());
         end
         if (v && bus32.in_ready) begin
            macc[8*mcnt +: 8] = d;
            mbe[mcnt] = 1'b1;
            if (mcnt == 3 || l) begin
               sb_q.push_back({27'b0, macc, mbe, l});
               macc = '0; mbe = '0; mcnt = 0;
            end else mcnt++;
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      bus32.in_valid = 1'b0;
      bus32.out_ready = 1'b1;
      repeat (4) begin
         #1;
         if (bus32.out_valid) begin
            chk("sb_have", sb_q.size() != 0, 1);
            obs = {27'b0, bus32.out_data, bus32.out_be, bus32.out_last};
            if (sb_q.size() != 0) chk("sb_word", obs, sb_q.pop_front());
         end
         @(negedge clk);
      end
      chk("sb_sent", sent, 10000);
      chk("sb_left", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
